// File: rtl/rv32_bus_pkg.sv
// Shared types and helpers for the memory-bus arbiter family.
package rv32_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  // Index width that never collapses to zero bits for a single-entry space.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]   address;
    logic                        read;
    logic                        write;
    logic [DEF_DATA_WIDTH/8-1:0] mask;
    logic [DEF_DATA_WIDTH-1:0]   value;
  } bus_req_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rv32_bus_arbiter_if.sv
// Bundle of N master request ports and the single slave port; the master modport
// is the arbiter's view (it masters the slave), the slave modport is the environment's.
interface rv32_bus_arbiter_if
  import rv32_bus_pkg::*;
#(
  parameter int  NUM_MASTERS = 2,
  parameter int  ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  localparam int MW          = DATA_WIDTH / 8,
  localparam int GW          = clog2_min1(NUM_MASTERS)
);
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address_in;
  logic [NUM_MASTERS-1:0]            m_read_in;
  logic [NUM_MASTERS-1:0]            m_write_in;
  logic [NUM_MASTERS*MW-1:0]         m_write_mask_in;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_value_in;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_read_value_out;
  logic [NUM_MASTERS-1:0]            m_ready_out;
  logic [ADDR_WIDTH-1:0]             s_address_out;
  logic                              s_read_out;
  logic                              s_write_out;
  logic [MW-1:0]                     s_write_mask_out;
  logic [DATA_WIDTH-1:0]             s_write_value_out;
  logic [DATA_WIDTH-1:0]             s_read_value_in;
  logic                              s_ready_in;
  logic [GW-1:0]                     grant_out;
  logic                              grant_valid_out;

  modport master (
    input  m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
    input  s_read_value_in, s_ready_in,
    output m_read_value_out, m_ready_out,
    output s_address_out, s_read_out, s_write_out, s_write_mask_out, s_write_value_out,
    output grant_out, grant_valid_out
  );

  modport slave (
    output m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
    output s_read_value_in, s_ready_in,
    input  m_read_value_out, m_ready_out,
    input  s_address_out, s_read_out, s_write_out, s_write_mask_out, s_write_value_out,
    input  grant_out, grant_valid_out
  );

endinterface

// File: rtl/rv32_rr_pick.sv
// Combinational picker: first set request from start upward with wrap (round-robin),
// or lowest set request (fixed priority). No state, zero latency.
module rv32_rr_pick
  import rv32_bus_pkg::*;
#(
  parameter int  N           = 2,
  parameter bit  ROUND_ROBIN = 1'b1,
  localparam int W           = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [W:0]   sum;
  logic [W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      if (ROUND_ROBIN) begin
        // start < N and k < N, so a single subtract is enough to wrap
        sum = {1'b0, start} + (W+1)'(k);
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        idx = sum[W-1:0];
      end else begin
        idx = W'(k);
      end
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rv32_bus_arbiter.sv
// N-master to 1-slave memory-bus arbiter: combinational pass-through when idle,
// grant locked to the owner while the slave holds ready low.
module rv32_bus_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int  NUM_MASTERS = 2,
  parameter int  ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter bit  ROUND_ROBIN = 1'b1,
  localparam int MW          = DATA_WIDTH / 8,
  localparam int GW          = clog2_min1(NUM_MASTERS)
) (
  input logic                clk,
  input logic                reset_n,
  rv32_bus_arbiter_if.master bus
);

  arb_state_t             state, state_nxt;
  logic [GW-1:0]          owner, owner_nxt;
  logic [GW-1:0]          last, last_nxt;
  logic [GW-1:0]          start, pick_idx, grantee;
  logic [NUM_MASTERS-1:0] req;
  logic                   pick_found, grant_valid;

  assign req   = bus.m_read_in | bus.m_write_in;
  assign start = (last == GW'(NUM_MASTERS-1)) ? '0 : last + GW'(1);

  rv32_rr_pick #(
    .N          (NUM_MASTERS),
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_pick (
    .req   (req),
    .start (start),
    .winner(pick_idx),
    .found (pick_found)
  );

  // A locked owner that withdraws yields an empty cycle rather than a new grant.
  assign grantee     = (state == ST_LOCKED) ? owner : pick_idx;
  assign grant_valid = (state == ST_LOCKED) ? req[owner] : pick_found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      owner <= '0;
      last  <= GW'(NUM_MASTERS-1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    owner_nxt = owner;
    last_nxt  = last;
    if (grant_valid) begin
      if (bus.s_ready_in) begin
        last_nxt = grantee;
      end else begin
        state_nxt = ST_LOCKED;
        owner_nxt = grantee;
      end
    end
  end

  assign bus.m_read_value_out = {NUM_MASTERS{bus.s_read_value_in}};

  always_comb begin
    bus.s_address_out     = '0;
    bus.s_read_out        = 1'b0;
    bus.s_write_out       = 1'b0;
    bus.s_write_mask_out  = '0;
    bus.s_write_value_out = '0;
    bus.m_ready_out       = '0;
    bus.grant_out         = '0;
    bus.grant_valid_out   = grant_valid;
    if (grant_valid) begin
      bus.s_address_out     = bus.m_address_in[grantee*ADDR_WIDTH +: ADDR_WIDTH];
      bus.s_read_out        = bus.m_read_in[grantee];
      bus.s_write_out       = bus.m_write_in[grantee];
      bus.s_write_mask_out  = bus.m_write_mask_in[grantee*MW +: MW];
      bus.s_write_value_out = bus.m_write_value_in[grantee*DATA_WIDTH +: DATA_WIDTH];
      bus.m_ready_out[grantee] = bus.s_ready_in;
      bus.grant_out         = grantee;
    end
  end

endmodule
